// File: rtl/fa4_bus_sequencer.sv
// Two-requester (fetch/data) arbiter and nibble-serial bus sequencer for the FA4 memory port.
// Define FA4_BUS_WAIT_EN to add the bus_rdy input, which stretches the data phase.
module fa4_bus_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset_L,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [3:0]        rdata,
  output logic [3:0]        bus_out,
  output logic              bus_oe,
  input  logic [3:0]        bus_in,
`ifdef FA4_BUS_WAIT_EN
  input  logic              bus_rdy,
`endif
  output logic              bus_sync,
  output logic              bus_we,
  output logic              busy
);

  localparam int NA   = ADDR_W / 4;
  localparam int CNT_W = (NA > 1) ? $clog2(NA) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  generate
    if (DATA_W != 4 || ADDR_W % 4 != 0 || ADDR_W < 4) begin : g_bad_param
      $error("fa4_bus_sequencer: DATA_W must be 4 and ADDR_W a nonzero multiple of 4");
    end
  endgenerate

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        wdata_q;
  logic              sel_d;
  logic              last_d;
  logic              data_go;
  logic              arb_ok;
  logic              f_cand;
  logic              d_cand;
  logic              grant_f;
  logic              grant_d;

`ifdef FA4_BUS_WAIT_EN
  assign data_go = bus_rdy;
`else
  assign data_go = 1'b1;
`endif

  // In DONE the requester being acked still holds its req; it must not win again.
  assign arb_ok  = (state == S_IDLE) || (state == S_DONE);
  assign f_cand  = arb_ok && f_req && !((state == S_DONE) && !sel_d);
  assign d_cand  = arb_ok && d_req && !((state == S_DONE) && sel_d);
  assign grant_f = f_cand && (!d_cand || last_d);
  assign grant_d = d_cand && !grant_f;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 4'h0;
      sel_d   <= 1'b0;
      last_d  <= 1'b1;
      f_ack   <= 1'b0;
      d_ack   <= 1'b0;
      rdata   <= 4'h0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (grant_f || grant_d) begin
            state   <= S_ADDR;
            cnt     <= '0;
            sel_d   <= grant_d;
            last_d  <= grant_d;
            addr_q  <= grant_d ? d_addr : f_addr;
            we_q    <= grant_d && d_we;
            wdata_q <= grant_d ? d_wdata : 4'h0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ADDR: begin
          // Low nibble is always presented; shift the next one down each phase.
          addr_q <= addr_q >> 4;
          if (cnt == CNT_W'(NA - 1)) begin
            state <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (data_go) begin
            if (!we_q) begin
              rdata <= bus_in;
            end
            state <= S_DONE;
            f_ack <= !sel_d;
            d_ack <= sel_d;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign bus_oe   = (state == S_ADDR) || ((state == S_DATA) && we_q);
  assign bus_sync = (state == S_ADDR) && (cnt == '0);
  assign bus_we   = ((state == S_ADDR) || (state == S_DATA)) && we_q;
  assign bus_out  = (state == S_ADDR) ? addr_q[3:0] :
                    ((state == S_DATA) && we_q) ? wdata_q : 4'h0;

endmodule
